regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the multicycle/pipelined MIPS datapath.
//  Provides NUM_RD async read ports and NUM_WR sync write ports, an optional hardwired-zero
//  register 0, optional write-to-read bypass, and a per-register busy scoreboard.
//  The scoreboard tracks pending producers (e.g. multicycle mult/div, load) for hazard logic.
// PARAMETERS
//  WIDTH       32  data width of each register
//  ADDR_WIDTH  5   address width; DEPTH = 1<<ADDR_WIDTH registers
//  NUM_RD      2   number of read ports (>=1)
//  NUM_WR      1   number of write ports (>=1)
//  ZERO_REG    1   1: register 0 always reads 0, writes/busy-sets to it ignored
//  BYPASS      1   1: same-cycle write data forwarded to matching read ports
// PORTS
//  clk          in   1                  clock, all state updates on posedge
//  reset        in   1                  synchronous, active-high
//  rd_addr      in   NUM_RD*ADDR_WIDTH  read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//  rd_data      out  NUM_RD*WIDTH       read data, port p at [p*WIDTH +: WIDTH]
//  rd_busy      out  NUM_RD             1 = addressed register has a pending producer
//  wr_en        in   NUM_WR             write enable per write port
//  wr_addr      in   NUM_WR*ADDR_WIDTH  write addresses
//  wr_data      in   NUM_WR*WIDTH       write data
//  wr_clr_busy  in   NUM_WR             1 = this write also clears busy bit of wr_addr
//  busy_set     in   1                  mark busy_addr busy (producer issued)
//  busy_addr    in   ADDR_WIDTH         register to mark busy
//  busy_vec     out  1<<ADDR_WIDTH      full scoreboard, bit i = register i busy
// BEHAVIOUR
//  - Reset: on posedge clk with reset=1 all registers <= 0, all busy bits <= 0; writes and
//    busy_set in that cycle ignored. Outputs follow: rd_data=0, rd_busy=0, busy_vec=0.
//  - Read: combinational, zero latency. rd_data[p] = MEM[rd_addr[p]].
//  - Write: MEM[wr_addr[w]] <= wr_data[w] on posedge when wr_en[w]=1 and reset=0.
//  - Write conflict: several enabled ports to one address -> highest port index wins.
//  - BYPASS=1: if any wr_en[w] with wr_addr[w]==rd_addr[p], rd_data[p] = that wr_data
//    (highest matching w) in the same cycle; rd_busy[p] shows the post-write-cycle
//    view, i.e. 0 if that winning write has wr_clr_busy=1 and no same-cycle busy_set.
//    BYPASS=0: reads return stored value; new data visible the cycle after the write.
//  - ZERO_REG=1: address 0 reads 0 and rd_busy 0 regardless of writes/bypass; MEM[0]
//    never written; busy_vec[0] always 0.
//  - Scoreboard next state per register i (reset=0):
//    set_i = busy_set && busy_addr==i; clr_i = any w: wr_en[w]&&wr_clr_busy[w]&&wr_addr[w]==i.
//    set_i -> 1 (set wins over simultaneous clr: new producer supersedes);
//    else clr_i -> 0; else hold. rd_busy[p] (BYPASS=0) = busy_vec[rd_addr[p]] registered.
//  - wr_clr_busy ignored when wr_en=0. Write to non-busy register with clr is legal, no effect.
//  - Reset asserted mid-operation overrides everything that cycle; no partial writes survive.
//  - No X propagation: all out-of-range concerns excluded by construction (full decode).
// TESTING
//  1 reset 1 cycle, read all 32 regs on 2 ports -> rd_data 0, busy_vec 0.
//  2 wr port0 addr 10 = 32'hDEADBEEF, rd_addr0=10 same cycle: BYPASS=1 -> DEADBEEF
//    immediately; BYPASS=0 -> 0 this cycle, DEADBEEF next cycle.
//  3 NUM_WR=2, both write addr 5 (0x1111, 0x2222) -> reads 0x2222 next cycle.
//  4 ZERO_REG=1: write addr 0 = 0xFFFFFFFF, busy_set addr 0 -> reads 0, busy_vec[0]=0.
//  5 busy_set addr 8 -> busy_vec[8]=1 next cycle; later write addr 8 with clr, and same
//    cycle busy_set addr 8 -> stays 1; next write with clr only -> 0.
//  6 write regs 1..3, assert reset with wr_en=1 to addr 4 -> all regs 0, addr 4 not written.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with bypass and busy scoreboard
module regfile_mp #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]      rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]      wr_data,
  input  logic [NUM_WR-1:0]            wr_clr_busy,
  input  logic                         busy_set,
  input  logic [ADDR_WIDTH-1:0]        busy_addr,
  output logic [(1<<ADDR_WIDTH)-1:0]   busy_vec
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH-1:0]      busyReg;
  logic [DEPTH-1:0]      busyNext;
  logic [ADDR_WIDTH-1:0] rAddr;
  logic [ADDR_WIDTH-1:0] wAddr;
  logic [WIDTH-1:0]      rData;
  logic                  rBusy;

  // Storage update; later write ports overwrite earlier ones so the highest index wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && !(ZERO_REG && (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == '0))) begin
          mem[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[w*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Scoreboard next state: clears first, then a new producer's set supersedes them.
  always_comb begin
    busyNext = busyReg;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && wr_clr_busy[w]) begin
        busyNext[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
    end
    if (busy_set) begin
      busyNext[busy_addr] = 1'b1;
    end
    if (ZERO_REG) begin
      busyNext[0] = 1'b0;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busyReg <= '0;
    end else begin
      busyReg <= busyNext;
    end
  end

  assign busy_vec = busyReg;

  // Async read ports; bypass shows the value and busy state as they will be after this edge.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rAddr   = '0;
    wAddr   = '0;
    rData   = '0;
    rBusy   = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      rAddr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      rData = mem[rAddr];
      rBusy = busyReg[rAddr];
      if (BYPASS && !reset) begin
        for (int w = 0; w < NUM_WR; w++) begin
          wAddr = wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH];
          if (wr_en[w] && (wAddr == rAddr)) begin
            rData = wr_data[w*WIDTH +: WIDTH];
            if (busy_set && (busy_addr == rAddr)) begin
              rBusy = 1'b1;
            end else if (wr_clr_busy[w]) begin
              rBusy = 1'b0;
            end else begin
              rBusy = busyReg[rAddr];
            end
          end
        end
      end
      if (ZERO_REG && (rAddr == '0)) begin
        rData = '0;
        rBusy = 1'b0;
      end
      rd_data[p*WIDTH +: WIDTH] = rData;
      rd_busy[p]                = rBusy;
    end
  end

endmodule
